muldiv_sequencer: RTL and testbench

//   Multi-cycle sequencer for the HI/LO multiply/divide resource of the multi-cycle MIPS core.
//   - Accepts one-hot start pulses from the main controller: mult, multu, div, divu.
//   - Runs one shared 32-step shift-add / restoring-divide engine.
//   - Holds the main controller via busy.
//   - Presents HI/LO results with a one-cycle write strobe.

---
 rtl/muldiv_sequencer.sv | 171 +++++++++++++++++
 tb/tb_muldiv_sequencer.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - HI/LO multi-cycle multiply/divide sequencer
module muldiv_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mul_start,
    input  logic             mulu_start,
    input  logic             div_start,
    input  logic             divu_start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             hi_lo_wen,
    output logic [WIDTH-1:0] hi_out,
    output logic [WIDTH-1:0] lo_out,
    output logic             div_zero
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_PREP = 3'd1;
    localparam logic [2:0] S_ITER = 3'd2;
    localparam logic [2:0] S_FIX  = 3'd3;
    localparam logic [2:0] S_DONE = 3'd4;

    // op encoding: bit1 = divide, bit0 = unsigned
    logic [2:0]         state_q, state_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0]   opa_q, opa_d, opb_q, opb_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic               sa_q, sa_d, sb_q, sb_d;
    logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic               dz_q, dz_d;

    logic               start_any;
    logic [1:0]         start_op;
    logic [WIDTH:0]     msum, rshift, rdiff;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo, rem;

    always_comb begin
        start_any = mul_start | mulu_start | div_start | divu_start;
        if (mul_start)       start_op = 2'd0;
        else if (mulu_start) start_op = 2'd1;
        else if (div_start)  start_op = 2'd2;
        else                 start_op = 2'd3;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        acc_d   = acc_q;
        sa_d    = sa_q;
        sb_d    = sb_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        dz_d    = dz_q;
        msum    = '0;
        rshift  = '0;
        rdiff   = '0;
        prod    = '0;
        quo     = '0;
        rem     = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start_any) begin
                    op_d    = start_op;
                    a_d     = a;
                    b_d     = b;
                    state_d = S_PREP;
                end
            end
            S_PREP: begin
                sa_d    = ~op_q[0] & a_q[WIDTH-1];
                sb_d    = ~op_q[0] & b_q[WIDTH-1];
                opa_d   = sa_d ? -a_q : a_q;
                opb_d   = sb_d ? -b_q : b_q;
                // divide keeps remainder:dividend in acc; multiply builds the product there
                acc_d   = op_q[1] ? {{WIDTH{1'b0}}, opa_d} : '0;
                cnt_d   = '0;
                state_d = S_ITER;
            end
            S_ITER: begin
                if (op_q[1]) begin
                    rshift = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
                    rdiff  = rshift - {1'b0, opb_q};
                    acc_d  = rdiff[WIDTH] ? {rshift[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                          : {rdiff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};
                end else begin
                    msum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (opb_q[0] ? {1'b0, opa_q} : '0);
                    acc_d = {msum, acc_q[WIDTH-1:1]};
                    opb_d = opb_q >> 1;
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) state_d = S_FIX;
            end
            S_FIX: begin
                if (op_q[1]) begin
                    quo = acc_q[WIDTH-1:0];
                    rem = acc_q[2*WIDTH-1:WIDTH];
                    if (b_q == '0) begin
                        lo_d = '1;
                        hi_d = a_q;
                    end else begin
                        lo_d = (sa_q ^ sb_q) ? -quo : quo;
                        hi_d = sa_q ? -rem : rem;
                    end
                end else begin
                    prod = (sa_q ^ sb_q) ? -acc_q : acc_q;
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end
                dz_d    = op_q[1] & (b_q == '0);
                state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            opa_q   <= '0;
            opb_q   <= '0;
            acc_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            acc_q   <= acc_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            dz_q    <= dz_d;
        end
    end

    assign busy      = (state_q == S_PREP) || (state_q == S_ITER) || (state_q == S_FIX);
    assign done      = (state_q == S_DONE);
    assign hi_lo_wen = done;
    assign div_zero  = done & dz_q;
    assign hi_out    = hi_q;
    assign lo_out    = lo_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// tb/tb_muldiv_sequencer.sv - self-checking bench for muldiv_sequencer
module tb_muldiv_sequencer;
    localparam int WIDTH = 32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mul_start = 1'b0, mulu_start = 1'b0, div_start = 1'b0, divu_start = 1'b0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done, hi_lo_wen, div_zero;
    logic [31:0] hi_out, lo_out;

    muldiv_sequencer #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .mul_start(mul_start), .mulu_start(mulu_start),
        .div_start(div_start), .divu_start(divu_start),
        .a(a), .b(b),
        .busy(busy), .done(done), .hi_lo_wen(hi_lo_wen),
        .hi_out(hi_out), .lo_out(lo_out), .div_zero(div_zero)
    );

    always #5 clk = ~clk;

    int   nvec = 0, nerr = 0;
    logic chk_en = 1'b0;

    // model: m_cnt counts down to the done cycle (1); >=2 means busy
    int          m_cnt = 0;
    logic [31:0] m_hi = '0, m_lo = '0, p_hi = '0, p_lo = '0;
    logic        m_dz = 1'b0, p_dz = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [1:0] sel_op(input logic m, input logic mu, input logic d);
        if (m)       return 2'd0;
        else if (mu) return 2'd1;
        else if (d)  return 2'd2;
        else         return 2'd3;
    endfunction

    function automatic void model_calc(input logic [1:0] op, input logic [31:0] av, input logic [31:0] bv,
                                       output logic [31:0] h, output logic [31:0] l, output logic z);
        longint      sa, sb, q, r;
        logic [63:0] p;
        z = 1'b0;
        case (op)
            2'd0: begin
                sa = longint'(signed'(av));
                sb = longint'(signed'(bv));
                p  = 64'(sa * sb);
                h  = p[63:32];
                l  = p[31:0];
            end
            2'd1: begin
                p = {32'b0, av} * {32'b0, bv};
                h = p[63:32];
                l = p[31:0];
            end
            default: begin
                if (bv == 32'd0) begin
                    l = 32'hFFFF_FFFF;
                    h = av;
                    z = 1'b1;
                end else begin
                    if (op == 2'd2) begin
                        sa = longint'(signed'(av));
                        sb = longint'(signed'(bv));
                    end else begin
                        sa = longint'({32'b0, av});
                        sb = longint'({32'b0, bv});
                    end
                    q = sa / sb;
                    r = sa % sb;
                    l = q[31:0];
                    h = r[31:0];
                end
            end
        endcase
    endfunction

    always @(posedge clk) begin
        logic [31:0] h, l;
        logic        z;
        if (rst) begin
            m_cnt <= 0;
            m_hi  <= '0;
            m_lo  <= '0;
            m_dz  <= 1'b0;
        end else if (m_cnt <= 1 && (mul_start | mulu_start | div_start | divu_start)) begin
            model_calc(sel_op(mul_start, mulu_start, div_start), a, b, h, l, z);
            p_hi  <= h;
            p_lo  <= l;
            p_dz  <= z;
            m_cnt <= WIDTH + 3;
        end else if (m_cnt > 0) begin
            m_cnt <= m_cnt - 1;
            if (m_cnt == 2) begin
                m_hi <= p_hi;
                m_lo <= p_lo;
                m_dz <= p_dz;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy",      busy,      m_cnt >= 2);
            chk("done",      done,      m_cnt == 1);
            chk("hi_lo_wen", hi_lo_wen, m_cnt == 1);
            chk("div_zero",  div_zero,  (m_cnt == 1) && m_dz);
            chk("hi_out",    hi_out,    m_hi);
            chk("lo_out",    lo_out,    m_lo);
        end
    end

    // st = {mul, mulu, div, divu}; operands scrambled after the start edge
    task automatic issue(input logic [3:0] st, input logic [31:0] av, input logic [31:0] bv);
        {mul_start, mulu_start, div_start, divu_start} = st;
        a = av;
        b = bv;
        @(posedge clk);
        #1;
        {mul_start, mulu_start, div_start, divu_start} = 4'b0;
        a = $urandom;
        b = $urandom;
    endtask

    task automatic wait_done(output int n, output int bc);
        n  = 0;
        bc = 0;
        while (n < 200) begin
            @(posedge clk);
            #1;
            n++;
            if (done) break;
            if (busy) bc++;
        end
        chk("done_seen", done, 1'b1);
    endtask

    int n, bc;

    initial begin
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        chk_en = 1'b1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_hi", hi_out, 0);
        chk("rst_lo", lo_out, 0);
        chk("rst_dz", div_zero, 0);

        issue(4'b0100, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(n, bc);
        chk("mulu_latency", n, 34);
        chk("mulu_busy_cycles", bc, 33);
        chk("mulu_hi", hi_out, 32'hFFFF_FFFE);
        chk("mulu_lo", lo_out, 32'h0000_0001);

        issue(4'b1000, 32'hFFFF_FFFD, 32'd5);
        wait_done(n, bc);
        chk("mul_neg_hi", hi_out, 32'hFFFF_FFFF);
        chk("mul_neg_lo", lo_out, 32'hFFFF_FFF1);

        issue(4'b0010, 32'hFFFF_FFF9, 32'd2);
        wait_done(n, bc);
        chk("div_n7_2_lo", lo_out, 32'hFFFF_FFFD);
        chk("div_n7_2_hi", hi_out, 32'hFFFF_FFFF);

        issue(4'b0010, 32'd7, 32'hFFFF_FFFE);
        wait_done(n, bc);
        chk("div_7_n2_lo", lo_out, 32'hFFFF_FFFD);
        chk("div_7_n2_hi", hi_out, 32'd1);

        issue(4'b0010, 32'hFFFF_FFF9, 32'hFFFF_FFFE);
        wait_done(n, bc);
        chk("div_n7_n2_lo", lo_out, 32'd3);
        chk("div_n7_n2_hi", hi_out, 32'hFFFF_FFFF);

        issue(4'b0001, 32'd7, 32'd0);
        wait_done(n, bc);
        chk("divu_zero_lo", lo_out, 32'hFFFF_FFFF);
        chk("divu_zero_hi", hi_out, 32'd7);
        chk("divu_zero_flag", div_zero, 1);

        issue(4'b0010, 32'hFFFF_FFF9, 32'd0);
        wait_done(n, bc);
        chk("div_zero_hi", hi_out, 32'hFFFF_FFF9);
        chk("div_zero_flag", div_zero, 1);

        issue(4'b0010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bc);
        chk("div_ovf_lo", lo_out, 32'h8000_0000);
        chk("div_ovf_hi", hi_out, 32'd0);
        chk("div_ovf_dz", div_zero, 0);

        issue(4'b0001, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(n, bc);
        chk("divu_big_lo", lo_out, 32'd0);
        chk("divu_big_hi", hi_out, 32'h8000_0000);

        issue(4'b0100, 32'h0001_0000, 32'h0001_0000);
        repeat (6) @(posedge clk);
        #1;
        div_start = 1'b1;
        a = 32'd5;
        b = 32'd1;
        @(posedge clk);
        #1;
        div_start = 1'b0;
        wait_done(n, bc);
        chk("ignored_start_hi", hi_out, 32'd1);
        chk("ignored_start_lo", lo_out, 32'd0);

        issue(4'b1010, 32'd6, 32'd7);
        wait_done(n, bc);
        chk("prio_lo", lo_out, 32'd42);
        chk("prio_hi", hi_out, 32'd0);

        issue(4'b0100, 32'h1234_5678, 32'h0000_0100);
        repeat (10) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_hi", hi_out, 0);
        chk("midrst_lo", lo_out, 0);

        issue(4'b0001, 32'd100, 32'd7);
        wait_done(n, bc);
        chk("divu_100_7_lo", lo_out, 32'd14);
        chk("divu_100_7_hi", hi_out, 32'd2);

        issue(4'b0100, 32'd3, 32'd4);
        wait_done(n, bc);
        chk("b2b_first_lo", lo_out, 32'd12);
        issue(4'b0001, 32'd9, 32'd2);
        chk("b2b_busy", busy, 1);
        wait_done(n, bc);
        chk("b2b_latency", n, 34);
        chk("b2b_lo", lo_out, 32'd4);
        chk("b2b_hi", hi_out, 32'd1);

        repeat (4) @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
